// File: rtl/image_filter_conv3x3_if.sv
// ---------------------------------------------------------------------------
// image_filter_conv3x3_if
// Avalon-MM slave bus bundle for the 3x3 convolution filter.
//   address     [3:0]  word address
//   read               read strobe
//   readdata    [31:0] read data (slave -> master)
//   write              write strobe
//   writedata   [31:0] write data
//   waitrequest        stall (slave -> master); master holds its request
// Modports: master (bridge side), slave (filter side).
// ---------------------------------------------------------------------------
interface image_filter_conv3x3_if;
  logic [3:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/image_filter_conv3x3.sv
// ---------------------------------------------------------------------------
// image_filter_conv3x3
// Avalon-MM slave holding a 3x3 pixel window, a programmable signed 3x3
// kernel, an output shift and a mode. Reading RESULT while the inputs have
// changed (dirty) runs a sequential 9-tap MAC per channel, stalling the bus
// with waitrequest for 11 cycles; clean reads and all other accesses are
// zero-wait.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   SW     [3]=1 overrides the mode with SW[1:0]; otherwise CTRL[1:0]
//   bus    Avalon-MM slave (address/read/readdata/write/writedata/waitrequest)
// Register map (word addresses):
//   0-8 PIX[k], 9-11 COEF (k(3j+i) at [i*COEF_W +: COEF_W] of word 9+j),
//   12 CTRL ([1:0] mode, [7:4] shift), 13 STATUS ([0] dirty, [1] busy,
//   [15:8] compute count), 14 RESULT, 15 reserved.
// ---------------------------------------------------------------------------
module image_filter_conv3x3 #(
  parameter int CH_W   = 8,
  parameter int NCH    = 3,
  parameter int COEF_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             SW,
  image_filter_conv3x3_if.slave  bus
);

  localparam int PIX_W  = NCH * CH_W;
  localparam int PROD_W = COEF_W + CH_W + 1;
  // 9 products of PROD_W bits need 4 more bits of headroom; one spare.
  localparam int ACC_W  = CH_W + COEF_W + 5;
  // Channel offsets used by gray; only meaningful when NCH == 3.
  localparam int R_LO   = (NCH == 3) ? 2 * CH_W : 0;
  localparam int G_LO   = (NCH == 3) ? CH_W : 0;

  typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

  state_t                    state;
  logic [PIX_W-1:0]          pix [9];
  logic signed [COEF_W-1:0]  coef [9];
  logic [1:0]                ctrl_mode;
  logic [3:0]                ctrl_shift;
  logic [PIX_W-1:0]          result;
  logic                      dirty;
  logic [7:0]                count;
  logic [3:0]                tap;
  logic signed [ACC_W-1:0]   acc [NCH];

  logic signed [PROD_W-1:0]  coef_ext;
  logic signed [PROD_W-1:0]  pix_ext [NCH];
  logic signed [PROD_W-1:0]  prod [NCH];
  logic                      start;
  logic                      wr_accept;
  logic [1:0]                eff_mode;
  logic [PIX_W-1:0]          kern_res;
  logic [PIX_W-1:0]          mode_res;
  logic [31:0]               rdata;
  logic                      unused_bits;

  // Arithmetic shift then clamp to the unsigned channel range.
  function automatic logic [CH_W-1:0] sat_ch(input logic signed [ACC_W-1:0] a,
                                             input logic [3:0] sh);
    logic signed [ACC_W-1:0] v;
    v = a >>> sh;
    if (v[ACC_W-1])
      return '0;
    else if (|v[ACC_W-2:CH_W])
      return '1;
    return v[CH_W-1:0];
  endfunction

  // Luma approximation (R + 2G + B) / 4, replicated to every channel.
  function automatic logic [PIX_W-1:0] gray_pix(input logic [PIX_W-1:0] p);
    logic [CH_W+1:0]  sum;
    logic [PIX_W-1:0] o;
    sum = {2'b00, p[R_LO +: CH_W]} + {1'b0, p[G_LO +: CH_W], 1'b0}
        + {2'b00, p[0 +: CH_W]};
    o = '0;
    for (int c = 0; c < NCH; c++)
      o[c*CH_W +: CH_W] = sum[CH_W+1:2];
    return o;
  endfunction

  assign eff_mode  = SW[3] ? SW[1:0] : ctrl_mode;
  assign start     = (state == IDLE) && bus.read && (bus.address == 4'd14) && dirty;
  // Read has priority: a write presented together with a read is not taken.
  assign wr_accept = (state == IDLE) && bus.write && !bus.read;

  assign bus.waitrequest = (state != IDLE) || start;
  assign bus.readdata    = rdata;

  // SW[2] has no function; writedata upper bits are ignored by most registers.
  assign unused_bits = ^{SW[2], bus.writedata};

  // ---- MAC product stage: signed coefficient x zero-extended channel ----
  always_comb begin
    coef_ext = PROD_W'(coef[tap]);
    for (int c = 0; c < NCH; c++) begin
      pix_ext[c] = PROD_W'($signed({1'b0, pix[tap][c*CH_W +: CH_W]}));
      prod[c]    = coef_ext * pix_ext[c];
    end
  end

  // ---- SAT stage: shift/clamp and mode selection ----
  always_comb begin
    kern_res = '0;
    for (int c = 0; c < NCH; c++)
      kern_res[c*CH_W +: CH_W] = sat_ch(acc[c], ctrl_shift);
  end

  always_comb begin
    mode_res = pix[4];
    case (eff_mode)
      2'd0: mode_res = pix[4];
      2'd1: mode_res = kern_res;
      2'd2: mode_res = (NCH == 3) ? gray_pix(pix[4]) : pix[4];
      2'd3: mode_res = ~pix[4];
      default: mode_res = pix[4];
    endcase
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      4'd9:    rdata = 32'({coef[2], coef[1], coef[0]});
      4'd10:   rdata = 32'({coef[5], coef[4], coef[3]});
      4'd11:   rdata = 32'({coef[8], coef[7], coef[6]});
      4'd12:   rdata = {24'd0, ctrl_shift, 2'b00, ctrl_mode};
      4'd13:   rdata = {16'd0, count, 6'd0, (state != IDLE), dirty};
      4'd14:   rdata = 32'(result);
      4'd15:   rdata = '0;
      default: rdata = 32'(pix[bus.address]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dirty      <= 1'b1;
      count      <= '0;
      ctrl_mode  <= '0;
      ctrl_shift <= '0;
      result     <= '0;
      for (int i = 0; i < 9; i++) begin
        pix[i]  <= '0;
        coef[i] <= (i == 4) ? COEF_W'(1) : '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= MAC;
            tap   <= '0;
            for (int c = 0; c < NCH; c++)
              acc[c] <= '0;
          end else if (wr_accept) begin
            if (bus.address <= 4'd12)
              dirty <= 1'b1;
            if (bus.address <= 4'd8)
              pix[bus.address] <= bus.writedata[PIX_W-1:0];
            case (bus.address)
              4'd9:
                for (int i = 0; i < 3; i++)
                  coef[i] <= bus.writedata[i*COEF_W +: COEF_W];
              4'd10:
                for (int i = 0; i < 3; i++)
                  coef[3+i] <= bus.writedata[i*COEF_W +: COEF_W];
              4'd11:
                for (int i = 0; i < 3; i++)
                  coef[6+i] <= bus.writedata[i*COEF_W +: COEF_W];
              4'd12: begin
                ctrl_mode  <= bus.writedata[1:0];
                ctrl_shift <= bus.writedata[7:4];
              end
              default: ;
            endcase
          end
        end
        // ---- MAC stage boundary: accumulate one tap per cycle ----
        MAC: begin
          for (int c = 0; c < NCH; c++)
            acc[c] <= acc[c] + {{(ACC_W-PROD_W){prod[c][PROD_W-1]}}, prod[c]};
          if (tap == 4'd8)
            state <= SAT;
          else
            tap <= tap + 4'd1;
        end
        // ---- SAT stage boundary: commit result, mode sampled here ----
        SAT: begin
          result <= mode_res;
          dirty  <= 1'b0;
          count  <= count + 8'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_filter_conv3x3.sv
module tb_image_filter_conv3x3;
  localparam int WAIT_LIMIT = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] SW;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [31:0] win [9];

  image_filter_conv3x3_if bus ();

  image_filter_conv3x3 #(.CH_W(8), .NCH(3), .COEF_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .SW    (SW),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int waits);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    waits = 0;
    #1;
    while (bus.waitrequest && waits < WAIT_LIMIT) begin
      waits++;
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output int waits);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    waits = 0;
    #1;
    while (bus.waitrequest && waits < WAIT_LIMIT) begin
      waits++;
      @(negedge clk); #1;
    end
    d = bus.readdata;
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  // Presents a RESULT read for one cycle only, launching a compute.
  task automatic kick_compute();
    @(negedge clk);
    bus.address = 4'd14; bus.read = 1'b1;
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  task automatic load_window();
    int w;
    for (int k = 0; k < 9; k++) bus_write(4'(k), win[k], w);
  endtask

  task automatic test_reset();
    logic [31:0] d; int w;
    n_cmp++; if (bus.waitrequest !== 1'b0) begin n_bad++; $display("FAIL reset_wait: got %b want 0", bus.waitrequest); end
    bus_read(4'd13, d, w);
    n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL reset_status: got %h want 00000001", d); end
    bus_read(4'd10, d, w);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL reset_coef10: got %h want 00000100", d); end
    bus_read(4'd9, d, w);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_coef9: got %h want 0", d); end
    bus_read(4'd12, d, w);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h want 0", d); end
    bus_read(4'd4, d, w);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_pix4: got %h want 0", d); end
  endtask

  task automatic test_bypass();
    logic [31:0] d; int w;
    load_window();
    bus_write(4'd1, 32'hFF3C_1E6D, w);
    n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL write_waits: got %0d want 0", w); end
    bus_read(4'd1, d, w);
    n_cmp++; if (d !== 32'h003C_1E6D) begin n_bad++; $display("FAIL pix_upper_zero: got %h want 003c1e6d", d); end
    bus_read(4'd15, d, w);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reserved_read: got %h want 0", d); end
    bus_read(4'd14, d, w);
    n_cmp++; if (w !== 11) begin n_bad++; $display("FAIL bypass_waits: got %0d want 11", w); end
    n_cmp++; if (d !== 32'h008E_6F78) begin n_bad++; $display("FAIL bypass_result: got %h want 008e6f78", d); end
    bus_read(4'd14, d, w);
    n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL clean_waits: got %0d want 0", w); end
    n_cmp++; if (d !== 32'h008E_6F78) begin n_bad++; $display("FAIL clean_result: got %h want 008e6f78", d); end
    bus_read(4'd13, d, w);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL bypass_status: got %h want 00000100", d); end
  endtask

  task automatic test_kernel_box();
    logic [31:0] d; int w;
    bus_write(4'd9,  32'h0001_0101, w);
    bus_write(4'd10, 32'h0001_0101, w);
    bus_write(4'd11, 32'h0001_0101, w);
    bus_write(4'd12, 32'h0000_0031, w);
    bus_read(4'd12, d, w);
    n_cmp++; if (d !== 32'h0000_0031) begin n_bad++; $display("FAIL ctrl_readback: got %h want 00000031", d); end
    bus_read(4'd14, d, w);
    n_cmp++; if (w !== 11) begin n_bad++; $display("FAIL box_waits: got %0d want 11", w); end
    n_cmp++; if (d !== 32'h0066_449C) begin n_bad++; $display("FAIL box_result: got %h want 0066449c", d); end
    bus_read(4'd13, d, w);
    n_cmp++; if (d !== 32'h0000_0200) begin n_bad++; $display("FAIL box_status: got %h want 00000200", d); end
  endtask

  task automatic test_clamp_high();
    logic [31:0] d; int w;
    bus_write(4'd9,  32'h0, w);
    bus_write(4'd10, 32'h0000_0200, w);
    bus_write(4'd11, 32'h0, w);
    bus_write(4'd12, 32'h0000_0001, w);
    bus_read(4'd14, d, w);
    n_cmp++; if (d !== 32'h00FF_DEF0) begin n_bad++; $display("FAIL clamp_high: got %h want 00ffdef0", d); end
  endtask

  task automatic test_laplacian();
    logic [31:0] d; int w;
    bus_write(4'd9,  32'h00FF_FFFF, w);
    bus_write(4'd10, 32'h00FF_08FF, w);
    bus_write(4'd11, 32'h00FF_FFFF, w);
    bus_read(4'd10, d, w);
    n_cmp++; if (d !== 32'h00FF_08FF) begin n_bad++; $display("FAIL coef_readback: got %h want 00ff08ff", d); end
    bus_read(4'd14, d, w);
    n_cmp++; if (d !== 32'h00FF_FF00) begin n_bad++; $display("FAIL laplacian: got %h want 00ffff00", d); end
  endtask

  task automatic test_sw_modes();
    logic [31:0] d; int w;
    SW = 4'b1011;
    bus_read(4'd13, d, w);
    n_cmp++; if (d !== 32'h0000_0400) begin n_bad++; $display("FAIL sw_not_dirty: got %h want 00000400", d); end
    bus_read(4'd14, d, w);
    n_cmp++; if (w !== 0 || d !== 32'h00FF_FF00) begin n_bad++; $display("FAIL sw_stale: got %h/%0d want 00ffff00/0", d, w); end
    bus_write(4'd12, 32'h0000_0001, w);
    bus_read(4'd14, d, w);
    n_cmp++; if (d !== 32'h0071_9087) begin n_bad++; $display("FAIL invert: got %h want 00719087", d); end
    SW = 4'b1010;
    bus_write(4'd12, 32'h0000_0001, w);
    bus_read(4'd14, d, w);
    n_cmp++; if (d !== 32'h0079_7979) begin n_bad++; $display("FAIL gray: got %h want 00797979", d); end
    SW = 4'b0000;
  endtask

  task automatic test_write_while_busy();
    logic [31:0] d; int w;
    bus_write(4'd12, 32'h0000_0000, w);
    kick_compute();
    bus_write(4'd0, 32'h0011_2233, w);
    n_cmp++; if (w !== 10) begin n_bad++; $display("FAIL busy_write_waits: got %0d want 10", w); end
    bus_read(4'd13, d, w);
    n_cmp++; if (d !== 32'h0000_0701) begin n_bad++; $display("FAIL busy_status: got %h want 00000701", d); end
    bus_read(4'd0, d, w);
    n_cmp++; if (d !== 32'h0011_2233) begin n_bad++; $display("FAIL busy_pix0: got %h want 00112233", d); end
    bus_read(4'd14, d, w);
    n_cmp++; if (w !== 11 || d !== 32'h008E_6F78) begin n_bad++; $display("FAIL busy_recompute: got %h/%0d want 008e6f78/11", d, w); end
  endtask

  task automatic test_reset_mid_compute();
    logic [31:0] d; int w;
    bus_write(4'd12, 32'h0000_0031, w);
    kick_compute();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.waitrequest !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", bus.waitrequest); end
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (bus.waitrequest !== 1'b0) begin n_bad++; $display("FAIL mid_wait_drop: got %b want 0", bus.waitrequest); end
    bus_read(4'd13, d, w);
    n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL mid_status: got %h want 00000001", d); end
    bus_read(4'd0, d, w);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_pix0: got %h want 0", d); end
    bus_read(4'd10, d, w);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL mid_coef10: got %h want 00000100", d); end
    bus_read(4'd12, d, w);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_ctrl: got %h want 0", d); end
    bus_read(4'd14, d, w);
    n_cmp++; if (w !== 11 || d !== 32'h0) begin n_bad++; $display("FAIL mid_result: got %h/%0d want 0/11", d, w); end
    bus_read(4'd13, d, w);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL mid_count: got %h want 00000100", d); end
  endtask

  initial begin
    win = '{32'h0032_1466, 32'h003C_1E6D, 32'h0046_2876, 32'h0050_3264, 32'h008E_6F78,
            32'h005A_3CF7, 32'h0064_46A9, 32'h006E_50AD, 32'h0078_5A71};
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    SW = 4'b0000;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_bypass();
    test_kernel_box();
    test_clamp_high();
    test_laplacian();
    test_sw_modes();
    test_write_while_busy();
    test_reset_mid_compute();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
